// File: rtl/uart_pkg.sv
// UART receiver shared constants and FSM encoding.
// Defaults give 2604 clocks per bit at 50 MHz / 19200 baud.
package uart_pkg;

  localparam int CLK_FREQ    = 50_000_000;
  localparam int BAUD        = 19200;
  localparam int BIT_CYCLES  = CLK_FREQ / BAUD;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect.
// Edges are only reported once the line has been seen high after reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rxd,
  output logic fall
);

  logic       s1;
  logic       s2;
  logic       prev;
  logic [1:0] fill;
  logic       armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      prev  <= 1'b1;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
      fill <= {fill[0], 1'b1};
      // a frame cut by reset stays ignored until the line idles high
      if (fill[1] && s2)
        armed <= 1'b1;
    end
  end

  assign rxd  = s2;
  assign fall = armed & prev & ~s2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualify at half bit, then
// single mid-bit samples for 8 data bits and the stop bit.
module uart_rx #(
  parameter int CLK_FREQ = uart_pkg::CLK_FREQ,
  parameter int BAUD     = uart_pkg::BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic [7:0] dout,
  output logic       dout_vld
);

  import uart_pkg::*;

  localparam int BIT_N  = CLK_FREQ / BAUD;
  localparam int HALF_N = BIT_N / 2;
  localparam int CW     = $clog2(BIT_N);

  localparam logic [CW-1:0] BIT_END  = CW'(BIT_N - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_N - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [7:0]      shreg;
  logic [2:0]      idx;
  logic            rxd;
  logic            fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .rxd   (rxd),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      idx      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (fall)
            state <= START;
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxd ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            shreg <= {rxd, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7)
              state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // back to IDLE at mid stop bit so the next start is caught
          if (cnt == BIT_END) begin
            cnt   <= '0;
            state <= IDLE;
            if (rxd) begin
              dout     <= shreg;
              dout_vld <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames queue expected bytes,
// a negedge monitor pops and checks data, pulse width and latency.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 62_500;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int HALF     = BIT / 2;
  localparam int LAT_LO   = 9 * BIT + HALF + 1;
  localparam int LAT_HI   = 9 * BIT + HALF + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b1;
  logic [7:0] dout;
  logic       dout_vld;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  int pushed = 0;
  int lat;
  int t0;
  logic [7:0] exp_q[$];
  int         t_q[$];
  logic [7:0] e;
  logic [7:0] hold = 8'h00;
  logic       vld_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // caller is always 1 time unit past a rising edge
  task automatic send(input logic [7:0] b, input logic stop,
                      input int gap, input bit expect_it,
                      input int rst_bit);
    if (expect_it) begin
      exp_q.push_back(b);
      t_q.push_back(cyc);
      pushed++;
    end
    din = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      if (i == rst_bit) begin
        tick(HALF);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(BIT - HALF - 2);
      end else begin
        tick(BIT);
      end
    end
    din = stop;
    tick(BIT);
    din = 1'b1;
    if (gap > 0) tick(gap * BIT);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold  = 8'h00;
      vld_d = 1'b0;
    end else begin
      if (dout_vld) begin
        pulses++;
        check("pulse_width", {31'd0, vld_d}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got %0h want none", dout);
        end else begin
          e   = exp_q.pop_front();
          t0  = t_q.pop_front();
          lat = cyc - t0;
          check("data", {24'd0, dout}, {24'd0, e});
          total++;
          if (lat < LAT_LO || lat > LAT_HI) begin
            bad++;
            $display("FAIL latency: got %0d want %0d..%0d",
                     lat, LAT_LO, LAT_HI);
          end
        end
        hold = dout;
      end else begin
        check("dout_hold", {24'd0, dout}, {24'd0, hold});
      end
      vld_d = dout_vld;
    end
  end

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         rg;
    din   = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check("reset_dout", {24'd0, dout}, 32'd0);
    check("reset_vld", {31'd0, dout_vld}, 32'd0);
    rst_n = 1'b1;
    tick(4 * BIT);

    for (int b = 5; b <= 14; b++)
      send(8'(b), 1'b1, 18, 1'b1, -1);
    check("seq_count", pulses, 10);

    din = 1'b0;
    tick(HALF / 2);
    din = 1'b1;
    tick(3 * BIT);
    check("glitch_no_pulse", pulses, pushed);
    send(8'hA5, 1'b1, 4, 1'b1, -1);

    send(8'h3C, 1'b0, 4, 1'b0, -1);
    check("frame_err_no_pulse", pulses, pushed);
    check("frame_err_hold", {24'd0, dout}, 32'hA5);
    send(8'hC3, 1'b1, 4, 1'b1, -1);

    send(8'h55, 1'b1, 0, 1'b1, -1);
    send(8'hAA, 1'b1, 4, 1'b1, -1);
    check("b2b_count", pulses, pushed);

    send(8'hF3, 1'b1, 4, 1'b0, 4);
    check("midreset_dout", {24'd0, dout}, 32'd0);
    check("midreset_no_pulse", pulses, pushed);
    send(8'h81, 1'b1, 4, 1'b1, -1);

    for (int k = 0; k < 24; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 7) != 0);
      rg = $urandom_range(0, 3);
      if (!rs && rg == 0) rg = 1;
      send(rb, rs, rg, rs, -1);
    end

    tick(4 * BIT);
    check("all_received", exp_q.size(), 0);
    check("pulse_count", pulses, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
